// File: rtl/lsu_pkg.sv
// Shared types for the load/store issue unit.
// Opcodes, FSM state encoding and the store-buffer entry layout.
package lsu_pkg;

    localparam int LSU_AW = 8;
    localparam int LSU_DW = 8;

    localparam logic [3:0] OP_LOAD    = 4'b1101;
    localparam logic [3:0] OP_STORE   = 4'b1110;
    localparam logic [3:0] OP_LOADIMM = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        LD_REQ,
        LD_WAIT
    } lsu_state_e;

    typedef struct packed {
        logic [LSU_AW-1:0] addr;
        logic [LSU_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/lsu_store_buf.sv
// In-order circular store buffer with count, head and tail pointers.
// LSU_STORE_FWD_EN adds a youngest-first address-match port.
module lsu_store_buf
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  sb_entry_t         push_entry,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic              next_empty,
    output sb_entry_t         next_head
`ifdef LSU_STORE_FWD_EN
    ,
    input  logic [LSU_AW-1:0] match_addr,
    output logic              match_hit,
    output logic [LSU_DW-1:0] match_data
`endif
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);

    sb_entry_t         mem [SB_DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_n;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(SB_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PW'(1);
            if (do_pop)  head <= head + PW'(1);
            count <= count_n;
        end
    end

    // Payload needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_entry;
    end

    // Head as it will be after this edge, so the request can be registered.
    always_comb begin
        count_n    = count + CW'(do_push) - CW'(do_pop);
        next_empty = (count_n == '0);
        if ((count - CW'(do_pop)) == '0) next_head = push_entry;
        else next_head = mem[head + PW'(do_pop)];
    end

`ifdef LSU_STORE_FWD_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        match_hit  = 1'b0;
        match_data = '0;
        idx        = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (mem[idx].addr == match_addr)) begin
                match_hit  = 1'b1;
                match_data = mem[idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/lsu_req_issuer.sv
// EX->DM load/store issue unit: store buffer drain, blocking loads, ALU pass-through.
// LSU_STORE_FWD_EN enables store-to-load forwarding from the store buffer.
module lsu_req_issuer
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int AW       = LSU_AW,
    parameter int DW       = LSU_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_wdata,
    input  logic [1:0]    ex_rd,
    output logic          ex_stall,
    output logic          dm_req_valid,
    output logic          dm_req_we,
    output logic [AW-1:0] dm_req_addr,
    output logic [DW-1:0] dm_req_wdata,
    input  logic          dm_req_ready,
    input  logic          dm_rsp_valid,
    input  logic [DW-1:0] dm_rsp_rdata,
    output logic          wb_valid,
    output logic [1:0]    wb_rd,
    output logic [DW-1:0] wb_data
);

    lsu_state_e    state;
    lsu_state_e    state_n;
    logic [AW-1:0] ld_addr;
    logic [AW-1:0] ld_addr_n;
    logic [1:0]    ld_rd;
    logic          is_ld;
    logic          is_st;
    logic          is_alu;
    logic          accept;
    logic          req_fire;
    logic          req_hold;
    logic          sb_full;
    logic          sb_empty;
    logic          sb_next_empty;
    logic          fwd_hit;
    sb_entry_t     sb_next_head;

    always_comb begin
        is_ld  = 1'b0;
        is_st  = 1'b0;
        is_alu = 1'b0;
        unique case (1'b1)
            (ex_opcode == OP_LOAD) || (ex_opcode == OP_LOADIMM): is_ld = 1'b1;
            (ex_opcode == OP_STORE):                             is_st = 1'b1;
            default:                                             is_alu = 1'b1;
        endcase
    end

    // A pop this cycle never frees room for an enqueue in the same cycle.
    assign ex_stall  = ex_valid && ((state != IDLE) || (is_st && sb_full));
    assign accept    = ex_valid && !ex_stall;
    assign req_fire  = dm_req_valid && dm_req_ready;
    assign req_hold  = dm_req_valid && !dm_req_ready;
    assign ld_addr_n = (accept && is_ld) ? ex_addr : ld_addr;

`ifdef LSU_STORE_FWD_EN
    logic [DW-1:0] fwd_data;

    lsu_store_buf #(.SB_DEPTH(SB_DEPTH)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept && is_st),
        .push_entry ('{addr: ex_addr, data: ex_wdata}),
        .pop        (req_fire && dm_req_we),
        .full       (sb_full),
        .empty      (sb_empty),
        .next_empty (sb_next_empty),
        .next_head  (sb_next_head),
        .match_addr (ex_addr),
        .match_hit  (fwd_hit),
        .match_data (fwd_data)
    );
`else
    assign fwd_hit = 1'b0;

    lsu_store_buf #(.SB_DEPTH(SB_DEPTH)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept && is_st),
        .push_entry ('{addr: ex_addr, data: ex_wdata}),
        .pop        (req_fire && dm_req_we),
        .full       (sb_full),
        .empty      (sb_empty),
        .next_empty (sb_next_empty),
        .next_head  (sb_next_head)
    );
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept && is_ld && !fwd_hit)
                         state_n = sb_empty ? LD_REQ : DRAIN;
            DRAIN:   if (sb_next_empty) state_n = LD_REQ;
            LD_REQ:  if (req_fire) state_n = LD_WAIT;
            LD_WAIT: if (dm_rsp_valid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ld_addr      <= '0;
            ld_rd        <= '0;
            dm_req_valid <= 1'b0;
            dm_req_we    <= 1'b0;
            dm_req_addr  <= '0;
            dm_req_wdata <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            state    <= state_n;
            ld_addr  <= ld_addr_n;
            wb_valid <= 1'b0;
            if (accept && is_ld) ld_rd <= ex_rd;
            if (accept && is_alu) begin
                wb_valid <= 1'b1;
                wb_rd    <= ex_rd;
                wb_data  <= ex_wdata;
            end
`ifdef LSU_STORE_FWD_EN
            if (accept && is_ld && fwd_hit) begin
                wb_valid <= 1'b1;
                wb_rd    <= ex_rd;
                wb_data  <= fwd_data;
            end
`endif
            if ((state == LD_WAIT) && dm_rsp_valid) begin
                wb_valid <= 1'b1;
                wb_rd    <= ld_rd;
                wb_data  <= dm_rsp_rdata;
            end
            // Request fields only move once the previous one is taken.
            if (!req_hold) begin
                if (state_n == LD_REQ) begin
                    dm_req_valid <= 1'b1;
                    dm_req_we    <= 1'b0;
                    dm_req_addr  <= ld_addr_n;
                    dm_req_wdata <= '0;
                end else if ((state_n != LD_WAIT) && !sb_next_empty) begin
                    dm_req_valid <= 1'b1;
                    dm_req_we    <= 1'b1;
                    dm_req_addr  <= sb_next_head.addr;
                    dm_req_wdata <= sb_next_head.data;
                end else begin
                    dm_req_valid <= 1'b0;
                    dm_req_we    <= 1'b0;
                    dm_req_addr  <= '0;
                    dm_req_wdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_req_issuer.sv
// Self-checking bench for lsu_req_issuer: vector table, request/writeback scoreboards.
// Also builds with LSU_STORE_FWD_EN defined.
module tb_lsu_req_issuer;
    import lsu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ex_valid;
    logic [3:0] ex_opcode;
    logic [7:0] ex_addr;
    logic [7:0] ex_wdata;
    logic [1:0] ex_rd;
    logic       ex_stall;
    logic       dm_req_valid;
    logic       dm_req_we;
    logic [7:0] dm_req_addr;
    logic [7:0] dm_req_wdata;
    logic       dm_req_ready;
    logic       dm_rsp_valid;
    logic [7:0] dm_rsp_rdata;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;

    lsu_req_issuer #(.SB_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .ex_stall     (ex_stall),
        .dm_req_valid (dm_req_valid),
        .dm_req_we    (dm_req_we),
        .dm_req_addr  (dm_req_addr),
        .dm_req_wdata (dm_req_wdata),
        .dm_req_ready (dm_req_ready),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rsp_rdata (dm_rsp_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } req_t;

    typedef struct {
        logic [1:0] rd;
        logic [7:0] data;
    } wbx_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [1:0] rd;
        bit         exp_wb;
        logic [7:0] exp_data;
        bit         exp_rd;
    } vec_t;

    req_t       req_q[$];
    wbx_t       wb_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] mem [256];
    int         lat = 1;
    int         rsp_cnt = 0;
    logic [7:0] rsp_addr = '0;
    vec_t       vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Memory responder: applies writes, answers reads after lat cycles.
    initial begin
        dm_rsp_valid = 1'b0;
        dm_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            #2;
            dm_rsp_valid = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    dm_rsp_valid = 1'b1;
                    dm_rsp_rdata = mem[rsp_addr];
                end
            end
            if (dm_req_valid && dm_req_ready) begin
                if (dm_req_we) mem[dm_req_addr] = dm_req_wdata;
                else begin
                    rsp_cnt  = lat;
                    rsp_addr = dm_req_addr;
                end
            end
        end
    end

    // Scoreboard monitor for memory requests and writebacks.
    initial begin
        req_t e;
        wbx_t w;
        forever begin
            @(negedge clk);
            #2;
            if (dm_req_valid && dm_req_ready) begin
                if (req_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL req_unexpected: got we=%0b addr=%0h, required none",
                             dm_req_we, dm_req_addr);
                end else begin
                    e = req_q.pop_front();
                    chk("req_we", 32'(dm_req_we), 32'(e.we));
                    chk("req_addr", 32'(dm_req_addr), 32'(e.addr));
                    if (e.we) chk("req_wdata", 32'(dm_req_wdata), 32'(e.data));
                end
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL wb_unexpected: got rd=%0d data=%0h, required none",
                             wb_rd, wb_data);
                end else begin
                    w = wb_q.pop_front();
                    chk("wb_rd", 32'(wb_rd), 32'(w.rd));
                    chk("wb_data", 32'(wb_data), 32'(w.data));
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d,
                         input logic [1:0] rd, input bit exp_wb, input logic [7:0] wd,
                         input bit exp_rd, input bit track);
        bit ok = 1'b0;
        if (track) begin
            if (op == OP_STORE) req_q.push_back('{1'b1, a, d});
            if (exp_rd) req_q.push_back('{1'b0, a, 8'h00});
            if (exp_wb) wb_q.push_back('{rd, wd});
        end
        ex_valid  = 1'b1;
        ex_opcode = op;
        ex_addr   = a;
        ex_wdata  = d;
        ex_rd     = rd;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (!ex_stall) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL issue_timeout: got ex_stall=1 for 200 cycles, required 0");
        end else begin
            @(negedge clk);
        end
        ex_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (req_q.size() == 0 && wb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending, required 0",
                     req_q.size() + wb_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ex_valid     = 1'b0;
        ex_opcode    = '0;
        ex_addr      = '0;
        ex_wdata     = '0;
        ex_rd        = '0;
        dm_req_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

        vt[0] = '{OP_STORE,   8'h30, 8'h11, 2'd0, 1'b0, 8'h00, 1'b0};
        vt[1] = '{OP_STORE,   8'h31, 8'h22, 2'd0, 1'b0, 8'h00, 1'b0};
        vt[2] = '{OP_STORE,   8'h32, 8'h33, 2'd0, 1'b0, 8'h00, 1'b0};
        vt[3] = '{4'b0000,    8'h00, 8'h01, 2'd1, 1'b1, 8'h01, 1'b0};
        vt[4] = '{4'b1100,    8'h00, 8'hFE, 2'd3, 1'b1, 8'hFE, 1'b0};
        vt[5] = '{4'b0111,    8'h00, 8'h80, 2'd0, 1'b1, 8'h80, 1'b0};
        vt[6] = '{OP_LOAD,    8'h31, 8'h00, 2'd2, 1'b1, 8'h22, 1'b1};
        vt[7] = '{OP_LOADIMM, 8'h30, 8'h00, 2'd1, 1'b1, 8'h11, 1'b1};
        vt[8] = '{OP_LOAD,    8'h32, 8'h00, 2'd3, 1'b1, 8'h33, 1'b1};
        vt[9] = '{OP_LOAD,    8'h40, 8'h00, 2'd0, 1'b1, 8'h1A, 1'b1};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs",
            32'({dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
                 wb_valid, wb_rd, wb_data, ex_stall}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU pass-through: writeback one cycle after acceptance.
        issue(4'b0101, 8'h00, 8'h3C, 2'd2, 1'b1, 8'h3C, 1'b0, 1'b1);
        #1;
        chk("alu_wb_valid", 32'(wb_valid), 32'h1);
        chk("alu_wb_data", 32'(wb_data), 32'h3C);
        chk("alu_wb_rd", 32'(wb_rd), 32'h2);
        @(negedge clk);

        // Single store: request at T+1, gone at T+2.
        issue(OP_STORE, 8'h10, 8'hAA, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        chk("st_req_valid", 32'(dm_req_valid), 32'h1);
        chk("st_req_we", 32'(dm_req_we), 32'h1);
        chk("st_req_addr", 32'(dm_req_addr), 32'h10);
        chk("st_req_wdata", 32'(dm_req_wdata), 32'hAA);
        @(negedge clk);
        #1;
        chk("st_req_done", 32'(dm_req_valid), 32'h0);
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            issue(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].rd,
                  vt[i].exp_wb, vt[i].exp_data, vt[i].exp_rd, 1'b1);
        wait_drain();

        // Full buffer: fifth store stalls until one cycle after the first pop.
        dm_req_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(OP_STORE, 8'h60 + 8'(i), 8'hA0 + 8'(i), 2'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        req_q.push_back('{1'b1, 8'h64, 8'hA4});
        ex_valid  = 1'b1;
        ex_opcode = OP_STORE;
        ex_addr   = 8'h64;
        ex_wdata  = 8'hA4;
        #1;
        chk("full_stall_0", 32'(ex_stall), 32'h1);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("full_stall_n", 32'(ex_stall), 32'h1);
        end
        @(negedge clk);
        dm_req_ready = 1'b1;
        #1;
        chk("full_no_bypass", 32'(ex_stall), 32'h1);
        @(negedge clk);
        #1;
        chk("full_freed", 32'(ex_stall), 32'h0);
        @(negedge clk);
        ex_valid = 1'b0;
        wait_drain();

        // Store then load to the same address.
        issue(OP_STORE, 8'h20, 8'h55, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1);
`ifdef LSU_STORE_FWD_EN
        issue(OP_LOAD, 8'h20, 8'h00, 2'd1, 1'b1, 8'h55, 1'b0, 1'b1);
        #1;
        chk("fwd_wb_valid", 32'(wb_valid), 32'h1);
        chk("fwd_wb_data", 32'(wb_data), 32'h55);
`else
        issue(OP_LOAD, 8'h20, 8'h00, 2'd1, 1'b1, 8'h55, 1'b1, 1'b1);
`endif
        wait_drain();

        // Ready low for 3 cycles on a load request.
        dm_req_ready = 1'b0;
        issue(OP_LOAD, 8'h70, 8'h00, 2'd2, 1'b1, 8'h2A, 1'b1, 1'b1);
        ex_valid  = 1'b1;
        ex_opcode = 4'b0011;
        ex_addr   = 8'h00;
        ex_wdata  = 8'h99;
        ex_rd     = 2'd3;
        repeat (3) begin
            #1;
            chk("ldhold_valid", 32'(dm_req_valid), 32'h1);
            chk("ldhold_we", 32'(dm_req_we), 32'h0);
            chk("ldhold_addr", 32'(dm_req_addr), 32'h70);
            chk("ldhold_stall", 32'(ex_stall), 32'h1);
            @(negedge clk);
        end
        dm_req_ready = 1'b1;
        issue(4'b0011, 8'h00, 8'h99, 2'd3, 1'b1, 8'h99, 1'b0, 1'b1);
        wait_drain();

        // Reset while waiting for read data; the late response is ignored.
        lat = 4;
        issue(OP_LOAD, 8'h50, 8'h00, 2'd1, 1'b0, 8'h00, 1'b1, 1'b1);
        wait_drain();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ldwait_outputs",
            32'({dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
                 wb_valid, wb_rd, wb_data}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_no_wb", 32'(wb_valid), 32'h0);
        end
        lat = 1;

        // Reset discards buffered stores.
        dm_req_ready = 1'b0;
        issue(OP_STORE, 8'h80, 8'hC1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        issue(OP_STORE, 8'h81, 8'hC2, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_sb_req", 32'(dm_req_valid), 32'h0);
        rst_n = 1'b1;
        dm_req_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("rst_sb_empty", 32'(dm_req_valid), 32'h0);
        end
        @(negedge clk);
        issue(OP_LOAD, 8'h80, 8'h00, 2'd2, 1'b1, 8'hDA, 1'b1, 1'b1);
        wait_drain();

        chk("queues_empty", 32'(req_q.size() + wb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
